knn_label_voter: RTL



---
 rtl/knn_label_voter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/knn_label_voter.sv
// knn_label_voter: majority vote over the K-nearest-neighbour list.
// The list is snapshotted on start. Each candidate entry is compared against
// every matcher entry, one matcher per cycle. The candidate's vote count is
// then compared with the running best.
// Optional build macro KNN_VOTER_DIST_TIE_EN: on an equal vote count, the
// candidate with the strictly smaller distance wins. Without the macro, the
// earlier (lowest-index) candidate keeps the lead.
module knn_label_voter #(
  parameter int K         = 4,
  parameter int DATA_INFO = 40,
  parameter int LABEL_W   = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K*DATA_INFO-1:0] nb_list,
  output logic                   busy,
  output logic                   done,
  output logic [LABEL_W-1:0]     label_out,
  output logic [CNT_W-1:0]       vote_cnt,
  output logic                   no_nb
);

  localparam int DIST_W = DATA_INFO - LABEL_W;
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // An all-ones distance marks an unfilled slot.
  function automatic logic entry_valid(input logic [DATA_INFO-1:0] e);
    return ~(&e[DATA_INFO-1:LABEL_W]);
  endfunction

  function automatic logic [LABEL_W-1:0] entry_label(input logic [DATA_INFO-1:0] e);
    return e[LABEL_W-1:0];
  endfunction

`ifdef KNN_VOTER_DIST_TIE_EN
  function automatic logic [DIST_W-1:0] entry_dist(input logic [DATA_INFO-1:0] e);
    return e[DATA_INFO-1:LABEL_W];
  endfunction
`endif

  logic [1:0]             state_r;
  logic [K*DATA_INFO-1:0] snap_r;
  logic [IDX_W-1:0]       cand_r;
  logic [IDX_W-1:0]       match_r;
  logic [CNT_W-1:0]       cur_cnt_r;
  logic [CNT_W-1:0]       best_cnt_r;
  logic [LABEL_W-1:0]     best_label_r;
  logic                   best_valid_r;
`ifdef KNN_VOTER_DIST_TIE_EN
  logic [DIST_W-1:0]      best_dist_r;
`endif

  logic [DATA_INFO-1:0]   cand_entry_s;
  logic [DATA_INFO-1:0]   match_entry_s;
  logic                   hit_s;
  logic                   take_s;
  logic                   nxt_best_valid_s;
  logic [LABEL_W-1:0]     nxt_best_label_s;
  logic [CNT_W-1:0]       nxt_best_cnt_s;

  assign cand_entry_s  = snap_r[cand_r*DATA_INFO +: DATA_INFO];
  assign match_entry_s = snap_r[match_r*DATA_INFO +: DATA_INFO];

  // Matcher hit: both entries valid and carrying the same label.
  always_comb begin
    hit_s = 1'b0;
    if (entry_valid(cand_entry_s) && entry_valid(match_entry_s)) begin
      hit_s = (entry_label(cand_entry_s) == entry_label(match_entry_s));
    end else begin
      hit_s = 1'b0;
    end
  end

  // Decide whether the current candidate displaces the running best.
  always_comb begin
    take_s = 1'b0;
    if (entry_valid(cand_entry_s)) begin
      if (!best_valid_r) begin
        take_s = 1'b1;
      end else if (cur_cnt_r > best_cnt_r) begin
        take_s = 1'b1;
      end else begin
`ifdef KNN_VOTER_DIST_TIE_EN
        take_s = (cur_cnt_r == best_cnt_r) &&
                 (entry_dist(cand_entry_s) < best_dist_r);
`else
        take_s = 1'b0;
`endif
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Best state after this UPDATE cycle; used to load the result on the last candidate.
  always_comb begin
    nxt_best_valid_s = best_valid_r;
    nxt_best_label_s = best_label_r;
    nxt_best_cnt_s   = best_cnt_r;
    if (take_s) begin
      nxt_best_valid_s = 1'b1;
      nxt_best_label_s = entry_label(cand_entry_s);
      nxt_best_cnt_s   = cur_cnt_r;
    end else begin
      nxt_best_valid_s = best_valid_r;
    end
  end

  // Vote FSM, snapshot, counters and registered result outputs.
  // The result and done are loaded on the edge into FINISH, so they are
  // visible during the FINISH cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      snap_r       <= {(K*DATA_INFO){1'b0}};
      cand_r       <= {IDX_W{1'b0}};
      match_r      <= {IDX_W{1'b0}};
      cur_cnt_r    <= {CNT_W{1'b0}};
      best_cnt_r   <= {CNT_W{1'b0}};
      best_label_r <= {LABEL_W{1'b0}};
      best_valid_r <= 1'b0;
`ifdef KNN_VOTER_DIST_TIE_EN
      best_dist_r  <= {DIST_W{1'b0}};
`endif
      busy         <= 1'b0;
      done         <= 1'b0;
      label_out    <= {LABEL_W{1'b0}};
      vote_cnt     <= {CNT_W{1'b0}};
      no_nb        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            snap_r       <= nb_list;
            cand_r       <= {IDX_W{1'b0}};
            match_r      <= {IDX_W{1'b0}};
            cur_cnt_r    <= {CNT_W{1'b0}};
            best_cnt_r   <= {CNT_W{1'b0}};
            best_valid_r <= 1'b0;
            busy         <= 1'b1;
            state_r      <= SCAN;
          end
        end
        SCAN: begin
          if (hit_s) begin
            cur_cnt_r <= cur_cnt_r + CNT_W'(1);
          end
          if (match_r == LAST_IDX) begin
            state_r <= UPDATE;
          end else begin
            match_r <= match_r + IDX_W'(1);
          end
        end
        UPDATE: begin
          best_valid_r <= nxt_best_valid_s;
          best_label_r <= nxt_best_label_s;
          best_cnt_r   <= nxt_best_cnt_s;
`ifdef KNN_VOTER_DIST_TIE_EN
          if (take_s) begin
            best_dist_r <= entry_dist(cand_entry_s);
          end
`endif
          cur_cnt_r <= {CNT_W{1'b0}};
          match_r   <= {IDX_W{1'b0}};
          if (cand_r == LAST_IDX) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= FINISH;
            if (nxt_best_valid_s) begin
              label_out <= nxt_best_label_s;
              vote_cnt  <= nxt_best_cnt_s;
              no_nb     <= 1'b0;
            end else begin
              label_out <= {LABEL_W{1'b0}};
              vote_cnt  <= {CNT_W{1'b0}};
              no_nb     <= 1'b1;
            end
          end else begin
            cand_r  <= cand_r + IDX_W'(1);
            state_r <= SCAN;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
